// File: rtl/booth_bist_pkg.sv
// Shared types and defaults for the Booth multiplier BIST driver.
package booth_bist_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_TIMEOUT = 15;
  localparam logic [7:0] DEF_MISR_POLY = 8'h1D;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_e;

endpackage

// File: rtl/booth_mult_driver_if.sv
// Operand stream, multiplier start/busy bus and result stream of the driver.
interface booth_mult_driver_if #(
  parameter int WIDTH = 4
);

  logic                 op_valid;
  logic                 op_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 m_start;
  logic [WIDTH-1:0]     m_a;
  logic [WIDTH-1:0]     m_b;
  logic                 m_busy;
  logic [2*WIDTH-1:0]   m_product;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_product;
  logic                 res_err;

  // master is the driver's view; slave is the surrounding environment.
  modport master (
    input  op_valid, op_a, op_b, m_busy, m_product, res_ready,
    output op_ready, m_start, m_a, m_b, res_valid, res_product, res_err
  );

  modport slave (
    output op_valid, op_a, op_b, m_busy, m_product, res_ready,
    input  op_ready, m_start, m_a, m_b, res_valid, res_product, res_err
  );

endinterface

// File: rtl/booth_mult_driver_misr.sv
// Galois MISR accumulating products into a signature; clear overrides update.
module misr_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = 8'h1D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/booth_mult_driver.sv
// Start/busy initiator for the Booth multiplier: one start per operand pair,
// timeout supervision, registered result stream and MISR signature.
module booth_mult_driver
  import booth_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter logic [2*WIDTH-1:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_mult_driver_if.master   bus,
  input  logic                  sig_clr,
  output logic                  err,
  output logic [2*WIDTH-1:0]    sig
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic                 m_start_q, m_start_d;
  logic [WIDTH-1:0]     m_a_q, m_a_d;
  logic [WIDTH-1:0]     m_b_q, m_b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0]   res_product_q, res_product_d;
  logic                 res_err_q, res_err_d;
  logic                 err_q, err_d;
  logic                 misr_en;
  logic                 op_ready;

  // Never offer to accept while the core is still finishing an earlier run.
  assign op_ready = (state_q == IDLE) && !bus.m_busy;

  always_comb begin
    state_d       = state_q;
    m_start_d     = 1'b0;
    m_a_d         = m_a_q;
    m_b_d         = m_b_q;
    cnt_d         = cnt_q;
    res_valid_d   = res_valid_q;
    res_product_d = res_product_q;
    res_err_d     = res_err_q;
    err_d         = err_q;
    misr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.op_valid && op_ready) begin
          m_a_d     = bus.op_a;
          m_b_d     = bus.op_b;
          cnt_d     = '0;
          m_start_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY, WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        // A completion seen on the last allowed cycle still counts as good.
        if (state_q == WAIT_DONE && !bus.m_busy) begin
          res_product_d = bus.m_product;
          res_err_d     = 1'b0;
          res_valid_d   = 1'b1;
          misr_en       = 1'b1;
          state_d       = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          err_d         = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = HOLD;
        end else if (state_q == WAIT_BUSY && bus.m_busy) begin
          state_d = WAIT_DONE;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      m_start_q     <= 1'b0;
      m_a_q         <= '0;
      m_b_q         <= '0;
      cnt_q         <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_err_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_start_q     <= m_start_d;
      m_a_q         <= m_a_d;
      m_b_q         <= m_b_d;
      cnt_q         <= cnt_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      res_err_q     <= res_err_d;
      err_q         <= err_d;
    end
  end

  misr_reg #(
    .WIDTH (2 * WIDTH),
    .POLY  (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (misr_en),
    .clr   (sig_clr),
    .data  (bus.m_product),
    .sig   (sig)
  );

  assign bus.op_ready    = op_ready;
  assign bus.m_start     = m_start_q;
  assign bus.m_a         = m_a_q;
  assign bus.m_b         = m_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_product_q;
  assign bus.res_err     = res_err_q;
  assign err             = err_q;

endmodule

// File: tb/tb_booth_mult_driver.sv
// Directed bench for booth_mult_driver with a behavioural start/busy multiplier.
module tb_booth_mult_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sig_clr;
  logic       err;
  logic [7:0] sig;

  int n_assert = 0;
  int n_fail = 0;
  int busy_len = 3;
  bit never_busy = 1'b0;
  int busy_left;
  int starts;
  int lat;
  int guard;

  booth_mult_driver_if #(.WIDTH(4)) bus ();

  booth_mult_driver #(
    .WIDTH     (4),
    .TIMEOUT   (15),
    .MISR_POLY (8'h1D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.master),
    .sig_clr (sig_clr),
    .err     (err),
    .sig     (sig)
  );

  always #5 clk = ~clk;

  // Multiplier model: busy rises the edge it sees start, lasts busy_len cycles.
  // It is a separate core and deliberately ignores the driver's reset.
  always @(posedge clk) begin
    if (bus.m_start && !never_busy) begin
      busy_left     <= busy_len;
      bus.m_product <= $signed(bus.m_a) * $signed(bus.m_b);
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign bus.m_busy = (busy_left != 0);

  always @(posedge clk) begin
    if (bus.m_start) starts <= starts + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic accept(input logic [3:0] a, input logic [3:0] b);
    int w;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_valid = 1'b1;
    w = 0;
    while (!bus.op_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("op_ready_timeout", {31'd0, bus.op_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.op_valid = 1'b0;
    $display("accept a=%0h b=%0h m_start=%0b", a, b, bus.m_start);
  endtask

  // Latency counted in negedges after the accepting edge (first one is 1).
  task automatic wait_res(output int l);
    l = 1;
    while (!bus.res_valid && l < 60) begin
      @(negedge clk);
      l++;
    end
    $display("result lat=%0d product=%0h err=%0b sig=%0h", l, bus.res_product, bus.res_err, sig);
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sig_clr = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
    chk("rst_m_start", {31'd0, bus.m_start}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_errs", {30'd0, bus.res_err, err}, 32'd0);
    chk("rst_regs", {8'd0, bus.m_a, bus.m_b, bus.res_product, sig}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 * 7 = 28 with a 3-cycle busy: result visible 6 cycles after accept.
    accept(4'd4, 4'd7);
    chk("op1_start", {31'd0, bus.m_start}, 32'd1);
    chk("op1_m_ab", {24'd0, bus.m_a, bus.m_b}, 32'h47);
    wait_res(lat);
    chk("op1_latency", lat, 6);
    chk("op1_product", bus.res_product, 32'd28);
    chk("op1_res_err", {31'd0, bus.res_err}, 32'd0);
    chk("op1_sig", sig, 32'h1C);
    chk("op1_starts", starts, 1);
    chk("op1_hold_op_ready", {31'd0, bus.op_ready}, 32'd0);
    handshake();

    // -4 * 5 = -20; sig = (1C<<1) ^ EC = D4.
    accept(4'hC, 4'd5);
    wait_res(lat);
    chk("op2_product", bus.res_product, 32'hEC);
    chk("op2_sig", sig, 32'hD4);

    // Stall downstream with a new operand already offered.
    bus.op_a = 4'd1;
    bus.op_b = 4'd1;
    bus.op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_product", bus.res_product, 32'hEC);
      chk("stall_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("stall_op_ready", {31'd0, bus.op_ready}, 32'd0);
    end
    chk("stall_starts", starts, 2);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    // Handshake edge must not also accept the waiting operand.
    chk("no_same_cycle_accept", {31'd0, bus.m_start}, 32'd0);
    chk("idle_after_hs", {31'd0, bus.op_ready}, 32'd1);
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("stall_starts_after", starts, 2);

    // Busy never rises: 15 waiting cycles, result at negedge 17.
    never_busy = 1'b1;
    accept(4'd2, 4'd3);
    wait_res(lat);
    chk("to_latency", lat, 17);
    chk("to_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("to_res_err", {31'd0, bus.res_err}, 32'd1);
    chk("to_product", bus.res_product, 32'd0);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_sig", sig, 32'hD4);
    handshake();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    never_busy = 1'b0;

    // Reset while in WAIT_DONE with a 6-cycle busy.
    busy_len = 6;
    accept(4'd1, 4'd2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_op_ready", {31'd0, bus.op_ready}, 32'd0);
    chk("mid_rst_flags", {28'd0, bus.m_start, bus.res_valid, bus.res_err, err}, 32'd0);
    chk("mid_rst_regs", {8'd0, bus.m_a, bus.m_b, bus.res_product, sig}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while (bus.m_busy && guard < 20) begin
      chk("busy_op_ready", {31'd0, bus.op_ready}, 32'd0);
      @(negedge clk);
      guard++;
    end
    chk("busy_dropped", {31'd0, bus.m_busy}, 32'd0);
    chk("post_rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("abandoned_not_reported", {31'd0, bus.res_valid}, 32'd0);

    // 3 * -2 = -6 with 2-cycle busy; sig restarts from 0.
    busy_len = 2;
    accept(4'd3, 4'hE);
    wait_res(lat);
    chk("op3_latency", lat, 5);
    chk("op3_product", bus.res_product, 32'hFA);
    chk("op3_res_err", {31'd0, bus.res_err}, 32'd0);
    chk("op3_sig", sig, 32'hFA);
    handshake();

    // sig_clr exactly on the update edge (negedge 4 precedes edge E+4).
    accept(4'd5, 4'd5);
    repeat (3) @(negedge clk);
    chk("clr_pre_sig", sig, 32'hFA);
    chk("clr_pre_valid", {31'd0, bus.res_valid}, 32'd0);
    sig_clr = 1'b1;
    @(negedge clk);
    sig_clr = 1'b0;
    $display("clr update valid=%0b product=%0h sig=%0h", bus.res_valid, bus.res_product, sig);
    chk("clr_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("clr_product", bus.res_product, 32'h19);
    chk("clr_sig", sig, 32'd0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
